cpu_test_monitor: RTL and testbench
===================================

Name: cpu_test_monitor

Overview:
- Synthesizable self-check monitor for the 16-bit pipelined CPU; sits beside `cpu`, snooping `num_inst`, `output_port` and `is_halted`.
- Holds a loadable table of (expected instruction count, expected output) pairs and checks them in order, so the CPU can be checked on FPGA without the simulation testbench.
- Adds behaviour the simulation bench lacks: run-time loadable table, in-order single-sample checking that is robust to stalls, skipped-entry detection, saturating cycle timeout, stop-on-fail mode and per-entry result readback.

Parameters:
- WORD_SIZE, 16, width of instruction count and data words.
- NUM_TEST, 56, number of table entries.
- IDX_W, 6, index width; 2^IDX_W >= NUM_TEST + 1.
- CYC_W, 16, cycle counter width.
- MAX_CYCLES, 10000, timeout limit in run cycles.
- STOP_ON_FAIL, 1, if 1, the first mismatch ends the run.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- cfg_we  in  1  table write strobe; honoured only in IDLE/DONE
- cfg_idx  in  IDX_W  table write index; writes with index >= NUM_TEST are ignored
- cfg_inst  in  WORD_SIZE  expected num_inst value for the entry
- cfg_ans  in  WORD_SIZE  expected output_port value for the entry
- start  in  1  pulse: clears results and enters RUN
- num_inst  in  WORD_SIZE  CPU retired-instruction count
- output_port  in  WORD_SIZE  CPU WWD output
- is_halted  in  1  CPU halt flag
- rd_idx  in  IDX_W  result readback index
- rd_result  out  2  registered result of rd_idx: 00 none, 01 pass, 10 fail, 11 skipped
- running  out  1  state == RUN
- done  out  1  state == DONE
- all_pass  out  1  done && pass_count == NUM_TEST
- timeout  out  1  run ended because cycle_count reached MAX_CYCLES
- pass_count  out  IDX_W  entries passed
- fail_count  out  IDX_W  entries failed or skipped
- first_fail_idx  out  IDX_W  index of the first failed or skipped entry
- first_fail_valid  out  1  first_fail_idx is meaningful
- cycle_count  out  CYC_W  cycles spent in RUN, saturating

Behaviour:
- Reset values: state IDLE; all outputs 0; all result flags 00. Table inst/ans storage is not reset.
- Reset mid-run aborts immediately to IDLE with every result cleared.
- States:
  - IDLE -> RUN on start.
  - RUN -> DONE on any end condition below.
  - DONE -> RUN on start. No other exits.
- On start (from IDLE or DONE), the next cycle has: ptr = 0, counters 0, result flags 00, first_fail_valid 0, timeout 0.
- RUN, each cycle, evaluated in this order:
  1. cycle_count increments, saturating at 2^CYC_W - 1.
  2. If ptr < NUM_TEST and num_inst == inst[ptr] (unsigned compare):
     - compare output_port against ans[ptr]; set flag 01 or 10;
     - increment pass_count or fail_count; increment ptr.
  3. Else if num_inst > inst[ptr] (entry missed):
     - set flag 11; increment fail_count; increment ptr.
  4. At most one entry is resolved per cycle. The next entry is examined in the following cycle even if num_inst is unchanged, so strictly ascending or equal table values are both legal.
  5. First fail or skip: latch first_fail_idx = ptr and set first_fail_valid; neither changes until the next start.
- Single sample: each entry is sampled on the first cycle its count matches. Later output_port changes while num_inst holds (stalls) are ignored.
- End conditions, checked after this cycle's resolution; this cycle's check still counts:
  - is_halted = 1;
  - ptr reaches NUM_TEST;
  - STOP_ON_FAIL and this cycle produced a fail or skip;
  - cycle_count reaches MAX_CYCLES; sets timeout.
  - Simultaneous end conditions all take effect; timeout is set whenever its condition holds.
- Entries left unresolved at DONE keep flag 00 and are not counted as fails.
- cfg_we during RUN is ignored; start during RUN is ignored.
- rd_result has 1-cycle latency and is valid in any state; rd_idx >= NUM_TEST returns 00.
- Expected implementation size: ~200 lines of RTL (table RAM, pointer, FSM, counters).

Test Plan:
- Load the 3 entries (3,0000), (5,0000), (7,0001). Start, then drive num_inst 3/5/7 with matching outputs, then is_halted -> done=1, all_pass=0 (NUM_TEST=56), pass_count=3, fail_count=0, flags 01,01,01, remaining entries 00.
- Entry 2 expects 0001, driven 0002, STOP_ON_FAIL=1 -> done on the following edge, fail_count=1, first_fail_idx=2, rd_result(2)=10, entries 3+ stay 00.
- num_inst jumps 3->9 past entries at 5 and 7 (STOP_ON_FAIL=0) -> entry 1 flag 11 in the jump cycle, entry 2 flag 11 the next cycle, fail_count=2, first_fail_idx=1.
- num_inst held at 5 for 4 stall cycles with output_port 0000 then FFFF -> entry passes (first sample only), pass_count increments once.
- Never reach entry 0 with MAX_CYCLES=20 -> done and timeout asserted at cycle_count=20; halt in the same cycle also ends the run with timeout=1.
- Assert reset_n low mid-run -> IDLE immediately, counters and flags 0. Start again -> the previously loaded table is re-checked correctly.

Source files
------------

// File: rtl/cpu_test_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cpu_test_monitor
//  Description : On-chip self-check monitor for the 16-bit pipelined CPU.
//                Walks a loadable table of (instruction count, expected
//                output) pairs in order, sampling output_port once per entry,
//                flagging skipped entries, and ending on halt, table end,
//                first failure (optional) or a saturating cycle timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_test_monitor #(
    parameter int WORD_SIZE    = 16,
    parameter int NUM_TEST     = 56,
    parameter int IDX_W        = 6,
    parameter int CYC_W        = 16,
    parameter int MAX_CYCLES   = 10000,
    parameter int STOP_ON_FAIL = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cfg_we,
    input  logic [IDX_W-1:0]     cfg_idx,
    input  logic [WORD_SIZE-1:0] cfg_inst,
    input  logic [WORD_SIZE-1:0] cfg_ans,
    input  logic                 start,
    input  logic [WORD_SIZE-1:0] num_inst,
    input  logic [WORD_SIZE-1:0] output_port,
    input  logic                 is_halted,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic [1:0]           rd_result,
    output logic                 running,
    output logic                 done,
    output logic                 all_pass,
    output logic                 timeout,
    output logic [IDX_W-1:0]     pass_count,
    output logic [IDX_W-1:0]     fail_count,
    output logic [IDX_W-1:0]     first_fail_idx,
    output logic                 first_fail_valid,
    output logic [CYC_W-1:0]     cycle_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] c_num_test   = IDX_W'(NUM_TEST);
    localparam logic [CYC_W-1:0] c_max_cycles = CYC_W'(MAX_CYCLES);
    localparam logic [CYC_W-1:0] c_cyc_sat    = '1;

    localparam logic [1:0] c_res_pass = 2'b01;
    localparam logic [1:0] c_res_fail = 2'b10;
    localparam logic [1:0] c_res_skip = 2'b11;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [WORD_SIZE-1:0]   r_inst [NUM_TEST];
    logic [WORD_SIZE-1:0]   r_ans  [NUM_TEST];
    logic [1:0]             r_flag [NUM_TEST];

    logic [IDX_W-1:0]       r_ptr;
    logic [IDX_W-1:0]       r_pass;
    logic [IDX_W-1:0]       r_fail;
    logic [IDX_W-1:0]       r_ffi;
    logic                   r_ffv;
    logic                   r_timeout;
    logic [CYC_W-1:0]       r_cyc;
    logic [1:0]             r_rd_result;

    logic                   w_start_ok;
    logic                   w_in_range;
    logic [IDX_W-1:0]       w_ptr_idx;
    logic [WORD_SIZE-1:0]   w_exp_inst;
    logic [WORD_SIZE-1:0]   w_exp_ans;
    logic                   w_hit;
    logic                   w_miss;
    logic                   w_good;
    logic                   w_bad;
    logic                   w_step;
    logic [IDX_W-1:0]       w_ptr_next;
    logic [CYC_W-1:0]       w_cyc_next;
    logic                   w_timeout_now;
    logic                   w_end;

    // Resolution of the entry under the pointer and the run end conditions
    always_comb begin
        w_start_ok    = start && (r_state != S_RUN);
        w_in_range    = (r_ptr < c_num_test);
        w_ptr_idx     = w_in_range ? r_ptr : '0;
        w_exp_inst    = r_inst[w_ptr_idx];
        w_exp_ans     = r_ans[w_ptr_idx];
        // Equal count samples the output once; a count already past the entry means it was missed
        w_hit         = w_in_range && (num_inst == w_exp_inst);
        w_miss        = w_in_range && !w_hit && (num_inst > w_exp_inst);
        w_good        = w_hit && (output_port == w_exp_ans);
        w_bad         = (w_hit && !w_good) || w_miss;
        w_step        = w_hit || w_miss;
        w_ptr_next    = w_step ? (r_ptr + IDX_W'(1)) : r_ptr;
        w_cyc_next    = (r_cyc == c_cyc_sat) ? r_cyc : (r_cyc + CYC_W'(1));
        w_timeout_now = (w_cyc_next >= c_max_cycles);
        w_end         = is_halted
                     || (w_ptr_next == c_num_test)
                     || ((STOP_ON_FAIL != 0) && w_bad)
                     || w_timeout_now;
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_end) w_state_next = S_DONE;
            S_DONE:  if (start) w_state_next = S_RUN;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Pointer, counters, per-entry result flags and first-failure latch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr     <= '0;
            r_pass    <= '0;
            r_fail    <= '0;
            r_ffi     <= '0;
            r_ffv     <= 1'b0;
            r_timeout <= 1'b0;
            r_cyc     <= '0;
            for (int i = 0; i < NUM_TEST; i++) r_flag[i] <= 2'b00;
        end else if (w_start_ok) begin
            r_ptr     <= '0;
            r_pass    <= '0;
            r_fail    <= '0;
            r_ffi     <= '0;
            r_ffv     <= 1'b0;
            r_timeout <= 1'b0;
            r_cyc     <= '0;
            for (int i = 0; i < NUM_TEST; i++) r_flag[i] <= 2'b00;
        end else if (r_state == S_RUN) begin
            r_cyc <= w_cyc_next;
            if (w_step) begin
                r_ptr <= w_ptr_next;
                r_flag[w_ptr_idx] <= w_miss ? c_res_skip :
                                     (w_good ? c_res_pass : c_res_fail);
            end
            if (w_good) r_pass <= r_pass + IDX_W'(1);
            if (w_bad) begin
                r_fail <= r_fail + IDX_W'(1);
                if (!r_ffv) begin
                    r_ffi <= r_ptr;
                    r_ffv <= 1'b1;
                end
            end
            if (w_timeout_now) r_timeout <= 1'b1;
        end
    end

    // Table storage: writable only while no run is in progress, not reset
    always_ff @(posedge clk) begin
        if (cfg_we && (r_state != S_RUN) && (cfg_idx < c_num_test)) begin
            r_inst[cfg_idx] <= cfg_inst;
            r_ans[cfg_idx]  <= cfg_ans;
        end
    end

    // Registered per-entry result readback
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_result <= 2'b00;
        end else begin
            r_rd_result <= (rd_idx < c_num_test) ? r_flag[rd_idx] : 2'b00;
        end
    end

    assign rd_result        = r_rd_result;
    assign running          = (r_state == S_RUN);
    assign done             = (r_state == S_DONE);
    assign all_pass         = (r_state == S_DONE) && (r_pass == c_num_test);
    assign timeout          = r_timeout;
    assign pass_count       = r_pass;
    assign fail_count       = r_fail;
    assign first_fail_idx   = r_ffi;
    assign first_fail_valid = r_ffv;
    assign cycle_count      = r_cyc;

endmodule
`default_nettype wire

// File: tb/tb_cpu_test_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_test_monitor
//  Description : Scoreboard bench for cpu_test_monitor. Two instances share
//                stimulus: A stops on first fail with a long timeout, B keeps
//                going with a 20-cycle timeout. Expected run summaries and
//                per-entry flags come from a table/queue reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_test_monitor;

    localparam int NT = 56;
    localparam int IW = 6;
    localparam int WS = 16;
    localparam int CW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n, cfg_we, start, is_halted;
    logic [IW-1:0] cfg_idx, rd_idx;
    logic [WS-1:0] cfg_inst, cfg_ans, num_inst, output_port;

    logic [1:0]    rd_a, rd_b;
    logic          run_a, run_b, done_a, done_b, ap_a, ap_b, to_a, to_b, ffv_a, ffv_b;
    logic [IW-1:0] pc_a, pc_b, fc_a, fc_b, ffi_a, ffi_b;
    logic [CW-1:0] cc_a, cc_b;

    cpu_test_monitor #(.STOP_ON_FAIL(1), .MAX_CYCLES(10000)) u_a (
        .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_inst(cfg_inst), .cfg_ans(cfg_ans), .start(start), .num_inst(num_inst),
        .output_port(output_port), .is_halted(is_halted), .rd_idx(rd_idx),
        .rd_result(rd_a), .running(run_a), .done(done_a), .all_pass(ap_a),
        .timeout(to_a), .pass_count(pc_a), .fail_count(fc_a),
        .first_fail_idx(ffi_a), .first_fail_valid(ffv_a), .cycle_count(cc_a));

    cpu_test_monitor #(.STOP_ON_FAIL(0), .MAX_CYCLES(20)) u_b (
        .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_inst(cfg_inst), .cfg_ans(cfg_ans), .start(start), .num_inst(num_inst),
        .output_port(output_port), .is_halted(is_halted), .rd_idx(rd_idx),
        .rd_result(rd_b), .running(run_b), .done(done_b), .all_pass(ap_b),
        .timeout(to_b), .pass_count(pc_b), .fail_count(fc_b),
        .first_fail_idx(ffi_b), .first_fail_valid(ffv_b), .cycle_count(cc_b));

    int errors = 0;
    int checks = 0;

    typedef struct {
        int pass; int fail; int ffi; int ffv; int tmo; int allp; int cc;
    } sum_t;

    sum_t       q_a[$], q_b[$];
    logic [1:0] qf_a[$], qf_b[$];

    // Reference data: table contents and the per-cycle CPU activity of a run
    logic [WS-1:0] t_inst[NT], t_ans[NT];
    int            L;
    logic [WS-1:0] c_in[128], c_out[128];
    logic          c_halt[128];
    logic [1:0]    ef[2][NT];
    int            end_k[2];
    sum_t          es[2];

    logic rd_req  = 1'b0;
    logic rd_pend = 1'b0;
    logic prev_a  = 1'b0;
    logic prev_b  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp_sum(input string tag, input sum_t e, input logic run, input logic ap,
                           input logic to, input logic [IW-1:0] pc, input logic [IW-1:0] fc,
                           input logic [IW-1:0] ffi, input logic ffv, input logic [CW-1:0] cc);
        chk({tag, "_running"}, 32'(run), 32'd0);
        chk({tag, "_pass"},    32'(pc),  32'(e.pass));
        chk({tag, "_fail"},    32'(fc),  32'(e.fail));
        chk({tag, "_ffv"},     32'(ffv), 32'(e.ffv));
        if (e.ffv != 0) chk({tag, "_ffi"}, 32'(ffi), 32'(e.ffi));
        chk({tag, "_timeout"}, 32'(to),  32'(e.tmo));
        chk({tag, "_allpass"}, 32'(ap),  32'(e.allp));
        chk({tag, "_cycles"},  32'(cc),  32'(e.cc));
    endtask

    // Reference model: walk the cycle list applying the checking rules directly
    task automatic model(input int d, input int stop, input int maxc);
        int   ptr, cc, verdict;
        bit   bad;
        sum_t s;
        ptr = 0; cc = 0;
        s = '{default: 0};
        for (int i = 0; i < NT; i++) ef[d][i] = 2'b00;
        end_k[d] = L - 1;
        for (int k = 0; k < L; k++) begin
            bad = 0; verdict = 0;
            if (cc < 65535) cc++;
            if (ptr < NT) begin
                if (c_in[k] == t_inst[ptr])     verdict = (c_out[k] == t_ans[ptr]) ? 1 : 2;
                else if (c_in[k] > t_inst[ptr]) verdict = 3;
            end
            if (verdict != 0) begin
                ef[d][ptr] = 2'(verdict);
                if (verdict == 1) s.pass++;
                else begin
                    s.fail++; bad = 1;
                    if (s.ffv == 0) begin s.ffi = ptr; s.ffv = 1; end
                end
                ptr++;
            end
            if (cc >= maxc) s.tmo = 1;
            if (c_halt[k] || ptr == NT || (stop != 0 && bad) || cc >= maxc) begin
                end_k[d] = k;
                break;
            end
        end
        s.cc   = cc;
        s.allp = (s.pass == NT) ? 1 : 0;
        es[d]  = s;
    endtask

    // Monitor: pops expectations when a run finishes or a readback returns
    always @(posedge clk) rd_pend <= rd_req;

    always @(negedge clk) begin
        if (done_a && !prev_a) begin
            if (q_a.size() == 0) chk("a_unexpected_done", 32'd1, 32'd0);
            else cmp_sum("a", q_a.pop_front(), run_a, ap_a, to_a, pc_a, fc_a, ffi_a, ffv_a, cc_a);
        end
        if (done_b && !prev_b) begin
            if (q_b.size() == 0) chk("b_unexpected_done", 32'd1, 32'd0);
            else cmp_sum("b", q_b.pop_front(), run_b, ap_b, to_b, pc_b, fc_b, ffi_b, ffv_b, cc_b);
        end
        if (rd_pend) begin
            if (qf_a.size() == 0 || qf_b.size() == 0) chk("rd_queue_empty", 32'd1, 32'd0);
            else begin
                chk("a_rd_result", 32'(rd_a), 32'(qf_a.pop_front()));
                chk("b_rd_result", 32'(rd_b), 32'(qf_b.pop_front()));
            end
        end
        prev_a <= done_a;
        prev_b <= done_b;
    end

    task automatic load_table();
        for (int i = 0; i < NT; i++) begin
            cfg_we = 1'b1; cfg_idx = IW'(i); cfg_inst = t_inst[i]; cfg_ans = t_ans[i];
            @(posedge clk); #1;
        end
        cfg_we = 1'b1; cfg_idx = IW'(60); cfg_inst = 16'h0000; cfg_ans = 16'h0000;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic set_cyc(input int k, input int n, input int o, input bit h);
        c_in[k] = WS'(n); c_out[k] = WS'(o); c_halt[k] = h;
    endtask

    task automatic readback();
        int idx;
        for (int i = 0; i < NT + 3; i++) begin
            idx = (i == NT + 2) ? 63 : i;
            rd_idx = IW'(idx); rd_req = 1'b1;
            qf_a.push_back((idx < NT) ? ef[0][idx] : 2'b00);
            qf_b.push_back((idx < NT) ? ef[1][idx] : 2'b00);
            @(posedge clk); #1;
        end
        rd_req = 1'b0;
        @(posedge clk); #1;
    endtask

    // One run: model both instances, start, replay the cycle list, read back flags
    task automatic do_run();
        model(0, 1, 10000);
        model(1, 0, 20);
        q_a.push_back(es[0]);
        q_b.push_back(es[1]);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < L; k++) begin
            num_inst = c_in[k]; output_port = c_out[k]; is_halted = c_halt[k];
            // Table writes and restarts while running must be ignored
            cfg_we   = (k == 0);
            cfg_idx  = IW'($urandom_range(0, 63));
            cfg_inst = WS'($urandom); cfg_ans = WS'($urandom);
            start    = (k == 1 && end_k[0] >= 1 && end_k[1] >= 1);
            @(posedge clk); #1;
        end
        cfg_we = 1'b0; start = 1'b0; is_halted = 1'b0;
        chk("run_ended", {30'd0, done_a, done_b}, 32'd3);
        readback();
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_running"}, {30'd0, run_a, run_b},  32'd0);
        chk({tag, "_done"},    {30'd0, done_a, done_b}, 32'd0);
        chk({tag, "_flags"},   {24'd0, ap_a, ap_b, to_a, to_b, ffv_a, ffv_b, 2'b00}, 32'd0);
        chk({tag, "_counts"},  {8'd0, pc_a, pc_b, fc_a, fc_b}, 32'd0);
        chk({tag, "_ffi"},     {20'd0, ffi_a, ffi_b}, 32'd0);
        chk({tag, "_cycles"},  {cc_a, cc_b}, 32'd0);
        chk({tag, "_rd"},      {28'd0, rd_a, rd_b}, 32'd0);
    endtask

    task automatic zero_expect();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < NT; i++) ef[d][i] = 2'b00;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, found;
        reset_n = 1'b0; cfg_we = 1'b0; start = 1'b0; is_halted = 1'b0;
        cfg_idx = '0; cfg_inst = '0; cfg_ans = '0; rd_idx = '0;
        num_inst = '0; output_port = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        check_idle("reset");
        zero_expect();
        readback();

        // Small directed table; unused entries sit at an unreachable count
        for (int i = 0; i < NT; i++) begin t_inst[i] = 16'hFFFF; t_ans[i] = 16'h0000; end
        t_inst[0] = 3; t_inst[1] = 5; t_inst[2] = 7; t_ans[2] = 1;
        load_table();

        // All three match, then halt
        L = 4; set_cyc(0, 3, 0, 0); set_cyc(1, 5, 0, 0); set_cyc(2, 7, 1, 0); set_cyc(3, 7, 1, 1);
        do_run();
        // Entry 2 mismatches
        L = 4; set_cyc(0, 3, 0, 0); set_cyc(1, 5, 0, 0); set_cyc(2, 7, 2, 0); set_cyc(3, 7, 2, 1);
        do_run();
        // Count jumps past entries 1 and 2
        L = 4; set_cyc(0, 3, 0, 0); set_cyc(1, 9, 0, 0); set_cyc(2, 9, 0, 0); set_cyc(3, 9, 0, 1);
        do_run();
        // Stall at count 5 with the output changing after the first sample
        L = 6; set_cyc(0, 3, 0, 0); set_cyc(1, 5, 0, 0);
        for (int k = 2; k < 6; k++) set_cyc(k, 5, 16'hFFFF, k == 5);
        do_run();
        // Entry 0 never reached: halt coincides with B's timeout, then halt later
        L = 20; for (int k = 0; k < 20; k++) set_cyc(k, 0, 0, k == 19);
        do_run();
        L = 25; for (int k = 0; k < 25; k++) set_cyc(k, 0, 0, k == 24);
        do_run();

        // Full table, every entry passing
        for (int i = 0; i < NT; i++) begin t_inst[i] = WS'(i + 1); t_ans[i] = WS'(i); end
        load_table();
        L = NT + 1;
        for (int k = 0; k < NT; k++) set_cyc(k, k + 1, k, 0);
        set_cyc(NT, NT, 0, 1);
        do_run();

        // Reset in the middle of a run, then re-run the same table
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            num_inst = c_in[k]; output_port = c_out[k]; @(posedge clk); #1;
        end
        #2 reset_n = 1'b0;
        #1 check_idle("midreset");
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        zero_expect();
        readback();
        do_run();

        // Randomized tables and CPU activity
        for (int it = 0; it < 8; it++) begin
            t_inst[0] = WS'($urandom_range(1, 3)); t_ans[0] = WS'($urandom_range(0, 3));
            for (int i = 1; i < NT; i++) begin
                t_inst[i] = t_inst[i-1] + WS'($urandom_range(0, 2));
                t_ans[i]  = WS'($urandom_range(0, 3));
            end
            load_table();
            L = $urandom_range(10, 90);
            n = 0;
            for (int k = 0; k < L; k++) begin
                if (k > 0) n += ($urandom_range(0, 9) == 0) ? 5 : $urandom_range(0, 2);
                found = -1;
                for (int j = NT - 1; j >= 0; j--) if (t_inst[j] == WS'(n)) found = j;
                if (found >= 0 && $urandom_range(0, 3) != 0) set_cyc(k, n, t_ans[found], k == L - 1);
                else set_cyc(k, n, $urandom_range(0, 3), k == L - 1);
            end
            do_run();
        end

        repeat (2) @(posedge clk);
        #1;
        chk("queues_drained", 32'(q_a.size() + q_b.size() + qf_a.size() + qf_b.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
